uart_tx_feeder: RTL

Byte-buffering front end for the 9600-baud UART transmit controller. Logic producers (button handlers, message sequencers) write bytes into an internal FIFO at clock speed, with no flow control beyond `full`. The feeder drains the FIFO into the transmit controller one byte at a time over its `send`/`ready` handshake, issuing each byte only when the controller reports idle. It sits directly upstream of the transmit controller, on the 100 MHz system clock.

---
 rtl/uart_pkg.sv | 14 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/uart_tx_feeder.sv | 67 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit controller and its byte feeder.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 9600;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_BUSY = 2'b10
  } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with occupancy count, drop-on-full overflow pulse
// and a registered head-data output that only changes on a pop.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic [BYTE_W-1:0] o_rd_data
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [BYTE_W-1:0] r_rd_data;
  logic              w_push;
  logic              w_pop;

  assign w_push     = i_wr_en && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_rd_data  = r_rd_data;

  // Storage needs no reset: a flush only has to clear pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_overflow <= i_wr_en && o_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART transmit
// controller over its send/ready handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [BYTE_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_tx_ready,
  output logic              o_tx_send,
  output logic [BYTE_W-1:0] o_tx_data
);

  feeder_state_t r_state;
  feeder_state_t w_next_state;
  logic          w_pop;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_pop      (w_pop),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_rd_data  (o_tx_data)
  );

  assign o_tx_send = (r_state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // WAIT_BUSY holds off the next request until the controller has visibly
  // left its ready state, so one frame is never requested twice.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!o_empty && i_tx_ready) begin
          w_pop        = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ:       w_next_state = WAIT_BUSY;
      WAIT_BUSY: if (!i_tx_ready) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

endmodule
